cdc_tx_arbiter: RTL
===================

// Module: cdc_tx_arbiter
// PURPOSE
//  a_clk-domain source controller for the a->b CDC data path.
//  Round-robin arbitrates N local requesters and captures the winning word.
//  Presents the word stable on a_data_out and sequences a 4-phase req/ack handshake with the b_clk-domain receiver.
//  b_ack is synchronised internally; a_data_out changes only while a_req and the synchronised ack are both low.
// PARAMETERS
//  K            8   data word width (matches b_data_out width)
//  N            4   number of requesters, N>=2
//  SYNC_STAGES  2   flops in the b_ack synchroniser, >=2
//  CNT_W        16  width of xfer_count
// PORTS
//  a_clk        in   1       source clock; the only clock of this block
//  rst          in   1       synchronous, active-high reset (sampled on a_clk rising edge)
//  en           in   1       enable; when low no new grant is issued
//  src_valid    in   N       per-requester word available
//  src_data     in   N*K     requester i word at [i*K +: K]
//  src_ready    out  N       one-hot accept strobe (combinational); word i consumed on this edge
//  a_req        out  1       handshake request to b domain, registered
//  a_data_out   out  K       captured word, registered, held for whole handshake
//  b_ack        in   1       handshake ack from b domain, asynchronous to a_clk
//  busy         out  1       1 whenever state != IDLE
//  grant_id     out  clog2N  index of requester currently in flight, registered
//  xfer_count   out  CNT_W   completed transfers, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset values: a_req=0, a_data_out=0, grant_id=0, xfer_count=0, busy=0, all synchroniser flops=0.
//  Reset also sets state=IDLE and rr_ptr=0, so index 0 has highest priority first.
//  ack_s = b_ack after SYNC_STAGES a_clk flops.
//  FSM states: IDLE, REQ, DROP.
//  IDLE:
//   - win = first i with src_valid[i], searching rr_ptr, rr_ptr+1, ... mod N.
//   - Grant condition: en && |src_valid && !ack_s.
//   - On grant: src_ready[win]=1 in that cycle.
//   - Next edge: a_data_out<=src_data[win], grant_id<=win, rr_ptr<=(win+1) mod N, a_req<=1, ->REQ.
//   - No grant: src_ready=0, all registers hold.
//  REQ: a_req=1. When ack_s==1: a_req<=0, ->DROP. Otherwise stay; no timeout.
//  DROP: a_req=0. When ack_s==0: xfer_count<=xfer_count+1, ->IDLE.
//  src_ready is 0 in REQ/DROP, and is at most one-hot.
//  Latency: grant edge -> a_req high 1 cycle later.
//   - Back-to-back transfers: the next grant is possible in the IDLE cycle right after DROP exits.
//  Boundaries:
//   - en falls mid-transfer: the current handshake completes normally; no further grant.
//   - ack_s high while IDLE (stale or spurious): grant blocked until ack_s low; never starts req.
//   - ack_s glitch low during REQ: ignored; only the 1 level advances the FSM.
//   - src_valid of the in-flight requester drops after acceptance: no effect, word already captured.
//   - Requester re-asserts valid while in flight: queued for the next round-robin turn.
//   - xfer_count at all-ones increments to 0.
//   - rst mid-handshake: a_req forced 0 at that edge and state=IDLE.
//     b side sees req fall; the partial transfer is dropped and not counted.
//   - All N valid continuously: grants ordered 0,1,..,N-1,0,... with no starvation.
// STRUCTURE
//  cdc_pkg.vh: state encodings (IDLE=2'd0, REQ=2'd1, DROP=2'd2), default K, SYNC_STAGES.
//  Sub-module cdc_sync_bit (SYNC_STAGES-flop synchroniser, sync active-high rst).
//   - Instantiated once for b_ack; reused later on the b side for a_req.
//  Round-robin winner search is a combinational function inside this module.
// TESTING
//  Periods: a_clk 20 ns, b_clk 14 ns. The bench models the b-side receiver: it syncs a_req, acks, and captures data.
//  1 Reset: rst high for 1 a_clk edge -> all outputs 0, busy=0, src_ready=0 regardless of src_valid.
//  2 Single transfer:
//    - Stimulus: en=1, src_valid=4'b0100, data[2]=8'hA5.
//    - Response: src_ready=4'b0100 for 1 cycle; a_req=1 next cycle; a_data_out=8'hA5 until ack_s falls.
//    - Response: b captures 8'hA5; xfer_count=1; grant_id=2.
//  3 Round-robin:
//    - Stimulus: src_valid=4'b1111 held, data[i]=8'h10+i.
//    - Response: received sequence 10,11,12,13,10,11; xfer_count=6.
//  4 Gating:
//    - Stimulus: en dropped while in REQ.
//    - Response: the transfer completes and xfer_count increments once.
//    - Response: no src_ready pulse while en=0 even with src_valid=4'b0011.
//  5 Stale ack:
//    - Stimulus: b_ack held 1, then src_valid=4'b0001.
//    - Response: no grant until b_ack low for SYNC_STAGES cycles, then a normal transfer.
//  6 Reset mid-op:
//    - Stimulus: rst pulsed while in REQ.
//    - Response: a_req=0 at that edge, xfer_count=0, rr_ptr=0.
//    - Response: the next src_valid=4'b1001 grants index 0 first.

Source files
------------

// File: rtl/cdc_tx_arbiter_pkg.sv
// Shared definitions for the a->b CDC source controller: FSM encoding and default sizes.
package cdc_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int DEF_K           = 8;
    localparam int DEF_N           = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/cdc_tx_arbiter_sync_bit.sv
// Multi-flop single-bit synchroniser with synchronous active-high reset.
module cdc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_tx_arbiter.sv
// a_clk-domain source side of the a->b CDC path: round-robin arbiter feeding a
// 4-phase req/ack handshake whose data word is held stable for the whole exchange.
module cdc_tx_arbiter
    import cdc_tx_arbiter_pkg::*;
#(
    parameter int K           = DEF_K,
    parameter int N           = DEF_N,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 a_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         src_valid,
    input  logic [N*K-1:0]       src_data,
    output logic [N-1:0]         src_ready,
    output logic                 a_req,
    output logic [K-1:0]         a_data_out,
    input  logic                 b_ack,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [CNT_W-1:0]     xfer_count
);

    localparam int IDX_W = $clog2(N);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_ack_s;
    logic               w_grant;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_a_req;
    logic [K-1:0]       r_a_data_out;
    logic [IDX_W-1:0]   r_grant_id;
    logic [CNT_W-1:0]   r_xfer_count;

    // Scanning offsets from high to low lets the lowest offset from ptr win last.
    function automatic logic [IDX_W:0] f_rr_search(input logic [N-1:0] valid,
                                                   input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (valid[j]) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    cdc_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk (a_clk),
        .rst (rst),
        .i_d (b_ack),
        .o_q (w_ack_s)
    );

    assign {w_found, w_win} = f_rr_search(src_valid, r_rr_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        src_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                // A stale ack still high from the b side must not start a new request.
                if (!rst && en && w_found && !w_ack_s) begin
                    w_grant          = 1'b1;
                    src_ready[w_win] = 1'b1;
                    w_state_nxt      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_ack_s) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!w_ack_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_a_req      <= 1'b0;
            r_a_data_out <= '0;
            r_grant_id   <= '0;
            r_xfer_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_a_data_out <= src_data[int'(w_win)*K +: K];
                r_grant_id   <= w_win;
                r_rr_ptr     <= (w_win == IDX_W'(N - 1)) ? '0 : w_win + 1'b1;
                r_a_req      <= 1'b1;
            end
            if (r_state == ST_REQ && w_ack_s) begin
                r_a_req <= 1'b0;
            end
            if (r_state == ST_DROP && !w_ack_s) begin
                r_xfer_count <= r_xfer_count + 1'b1;
            end
        end
    end

    assign a_req      = r_a_req;
    assign a_data_out = r_a_data_out;
    assign grant_id   = r_grant_id;
    assign xfer_count = r_xfer_count;
    assign busy       = (r_state != ST_IDLE);

endmodule
